// File: rtl/ram_mport_init.sv
// Multi-ported register-file RAM with clear sequencer, write priority/conflict
// detection, optional write-to-read bypass and optional registered read path.
module ram_mport_init #(
    parameter int              DEPTH      = 16,
    parameter int              INDEX      = 4,
    parameter int              WIDTH      = 8,
    parameter int              NUM_RD     = 8,
    parameter int              NUM_WR     = 4,
    parameter int              RD_LATENCY = 0,
    parameter int              BYPASS     = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_i,
    output logic                     ready_o,
    input  logic [NUM_RD*INDEX-1:0]  rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0]  rd_data_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*INDEX-1:0]  wr_addr_i,
    input  logic [NUM_WR*WIDTH-1:0]  wr_data_i,
    output logic                     wr_conflict_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [INDEX-1:0] LAST = INDEX'(DEPTH - 1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t           state;
    logic [INDEX-1:0] clr_cnt;
    logic             ready_q;
    logic             conflict_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [NUM_WR-1:0] wr_ok;
    logic             collide;

    function automatic logic in_range(input logic [INDEX-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // A write port is live only in READY and only for in-range addresses.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++)
            wr_ok[w] = wr_en_i[w] && (state == READY) && in_range(wr_addr_i[w*INDEX +: INDEX]);
    end

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (wr_ok[i] && wr_ok[j] && wr_addr_i[i*INDEX +: INDEX] == wr_addr_i[j*INDEX +: INDEX])
                    collide = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    conflict_q <= 1'b0;
                    clr_cnt    <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    conflict_q <= collide;
                    if (init_i) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Ascending port order: the highest-numbered port's assignment lands last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[clr_cnt[AW-1:0]] <= INIT_VALUE;
            else
                for (int w = 0; w < NUM_WR; w++)
                    if (wr_ok[w])
                        mem[wr_addr_i[w*INDEX +: AW]] <= wr_data_i[w*WIDTH +: WIDTH];
        end
    end

    assign ready_o       = ready_q;
    assign wr_conflict_o = conflict_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [INDEX-1:0] addr;
        logic [WIDTH-1:0] val;

        assign addr = rd_addr_i[p*INDEX +: INDEX];

        always_comb begin
            val = INIT_VALUE;
            if (state == READY && in_range(addr)) begin
                val = mem[addr[AW-1:0]];
                if (BYPASS != 0)
                    for (int w = 0; w < NUM_WR; w++)
                        if (wr_ok[w] && wr_addr_i[w*INDEX +: INDEX] == addr)
                            val = wr_data_i[w*WIDTH +: WIDTH];
            end
        end

        if (RD_LATENCY != 0) begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk) begin
                if (reset || state == CLEAR) q <= INIT_VALUE;
                else                         q <= val;
            end
            // Mask the first CLEAR cycle, whose register was loaded in READY.
            assign rd_data_o[p*WIDTH +: WIDTH] = (state == READY) ? q : INIT_VALUE;
        end else begin : g_comb
            assign rd_data_o[p*WIDTH +: WIDTH] = val;
        end
    end
endmodule

// File: tb/tb_ram_mport_init.sv
// Self-checking bench: four ram_mport_init variants (latency x bypass) driven in
// lockstep and compared each cycle with a behavioural array model.
module tb_ram_mport_init;
    localparam int DEPTH = 16, INDEX = 5, WIDTH = 8, NR = 8, NW = 4;
    localparam logic [7:0] INIT = 8'hA5;

    logic clk = 1'b0, reset = 1'b1, init = 1'b0;
    logic [NR*INDEX-1:0] rd_addr = '0;
    logic [NW-1:0]       wr_en = '0;
    logic [NW*INDEX-1:0] wr_addr = '0;
    logic [NW*WIDTH-1:0] wr_data = '0;
    logic [NR*WIDTH-1:0] rd_data [4];
    logic [3:0]          ready, conflict;

    always #5 clk = ~clk;

    ram_mport_init #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NR), .NUM_WR(NW),
                     .RD_LATENCY(0), .BYPASS(1), .INIT_VALUE(INIT)) dut_l0b1 (
        .clk(clk), .reset(reset), .init_i(init), .ready_o(ready[0]), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data[0]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_conflict_o(conflict[0]));
    ram_mport_init #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NR), .NUM_WR(NW),
                     .RD_LATENCY(0), .BYPASS(0), .INIT_VALUE(INIT)) dut_l0b0 (
        .clk(clk), .reset(reset), .init_i(init), .ready_o(ready[1]), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data[1]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_conflict_o(conflict[1]));
    ram_mport_init #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NR), .NUM_WR(NW),
                     .RD_LATENCY(1), .BYPASS(1), .INIT_VALUE(INIT)) dut_l1b1 (
        .clk(clk), .reset(reset), .init_i(init), .ready_o(ready[2]), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data[2]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_conflict_o(conflict[2]));
    ram_mport_init #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_RD(NR), .NUM_WR(NW),
                     .RD_LATENCY(1), .BYPASS(0), .INIT_VALUE(INIT)) dut_l1b0 (
        .clk(clk), .reset(reset), .init_i(init), .ready_o(ready[3]), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data[3]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_conflict_o(conflict[3]));

    int checks = 0, errors = 0;

    // Stimulus in unpacked form, shared by the drivers and the model.
    logic [4:0] ra [NR];
    logic [4:0] wa [NW];
    logic [7:0] wd [NW];
    logic       we [NW];

    // Model: array contents, usable flag, clear progress, expected registered reads.
    logic [7:0] mm [DEPTH];
    bit         m_ready = 0;
    int         m_cnt = 0;
    bit         m_conf = 0;
    bit         reg_valid = 0;
    logic [7:0] m_reg [4][NR];
    bit         chk_en = 0;

    function automatic bit is_lat1(input int k); return k >= 2; endfunction
    function automatic bit is_byp(input int k);  return (k % 2) == 0; endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NR; p++) rd_addr[p*INDEX +: INDEX] = ra[p];
        for (int w = 0; w < NW; w++) begin
            wr_en[w]                 = we[w];
            wr_addr[w*INDEX +: INDEX] = wa[w];
            wr_data[w*WIDTH +: WIDTH] = wd[w];
        end
    endtask

    task automatic idle();
        for (int w = 0; w < NW; w++) begin we[w] = 0; wa[w] = '0; wd[w] = '0; end
        for (int p = 0; p < NR; p++) ra[p] = '0;
        drive();
    endtask

    task automatic rand_in(input int amax, input int en_pct);
        for (int p = 0; p < NR; p++) ra[p] = 5'($urandom_range(amax, 0));
        for (int w = 0; w < NW; w++) begin
            we[w] = ($urandom_range(99, 0) < en_pct);
            wa[w] = 5'($urandom_range(amax, 0));
            wd[w] = 8'($urandom);
        end
        drive();
    endtask

    // What a read of port p sees this cycle, optionally including live writes.
    function automatic logic [7:0] exp_rd(input int p, input bit byp);
        logic [7:0] v;
        if (!m_ready || ra[p] >= DEPTH) return INIT;
        v = mm[ra[p]];
        if (byp)
            for (int w = 0; w < NW; w++)
                if (we[w] && wa[w] == ra[p]) v = wd[w];
        return v;
    endfunction

    task automatic check_all();
        logic [7:0] e;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dut%0d ready", k), 32'(ready[k]), 32'(m_ready));
            chk($sformatf("dut%0d conflict", k), 32'(conflict[k]), 32'(m_conf));
            for (int p = 0; p < NR; p++) begin
                if (!is_lat1(k))      e = exp_rd(p, is_byp(k));
                else if (!m_ready)    e = INIT;
                else if (reg_valid)   e = m_reg[k][p];
                else continue;
                chk($sformatf("dut%0d rd%0d", k, p), 32'(rd_data[k][p*WIDTH +: WIDTH]), 32'(e));
            end
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_ready = 0; m_cnt = 0; m_conf = 0; reg_valid = 0;
        end else if (!m_ready) begin
            mm[m_cnt] = INIT;
            m_cnt++;
            m_conf = 0; reg_valid = 0;
            if (m_cnt == DEPTH) m_ready = 1;
        end else begin
            for (int k = 0; k < 4; k++)
                for (int p = 0; p < NR; p++) m_reg[k][p] = exp_rd(p, is_byp(k));
            reg_valid = 1;
            m_conf = 0;
            for (int i = 0; i < NW; i++)
                for (int j = i + 1; j < NW; j++)
                    if (we[i] && we[j] && wa[i] == wa[j] && wa[i] < DEPTH) m_conf = 1;
            for (int w = 0; w < NW; w++)
                if (we[w] && wa[w] < DEPTH) mm[wa[w]] = wd[w];
            if (init) begin m_ready = 0; m_cnt = 0; end
        end
    endtask

    task automatic tick();
        #1;
        if (chk_en) check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (ready[0] !== 1'b1 && n < 40) begin
            rand_in(19, 80);
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = INIT;
        @(negedge clk);
        reset = 1; rand_in(19, 80);
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        count_clear("clear_len_after_reset");

        // Port 0 writes addr 3, port 5 reads it in the same and next cycle.
        idle(); we[0] = 1; wa[0] = 3; wd[0] = 8'h11; ra[5] = 3; drive();
        #1;
        chk("bypass_same_cycle", 32'(rd_data[0][5*WIDTH +: WIDTH]), 32'h11);
        chk("nobypass_same_cycle", 32'(rd_data[1][5*WIDTH +: WIDTH]), 32'hA5);
        tick();
        idle(); ra[5] = 3; drive();
        #1;
        chk("nobypass_next_cycle", 32'(rd_data[1][5*WIDTH +: WIDTH]), 32'h11);
        chk("reg_bypass_next", 32'(rd_data[2][5*WIDTH +: WIDTH]), 32'h11);
        chk("reg_nobypass_next", 32'(rd_data[3][5*WIDTH +: WIDTH]), 32'hA5);
        tick();

        // Ports 1 and 3 collide on addr 7.
        idle(); we[1] = 1; wa[1] = 7; wd[1] = 8'h22; we[3] = 1; wa[3] = 7; wd[3] = 8'h33; drive();
        tick();
        idle(); ra[0] = 7; drive();
        #1;
        chk("conflict_pulse", 32'(conflict[0]), 32'h1);
        chk("collide_winner", 32'(rd_data[0][0 +: WIDTH]), 32'h33);
        tick();
        idle(); we[0] = 1; wa[0] = 1; wd[0] = 8'h44; we[2] = 1; wa[2] = 2; wd[2] = 8'h55; drive();
        #1;
        chk("conflict_one_cycle", 32'(conflict[0]), 32'h0);
        tick();
        idle(); ra[1] = 7; drive();
        #1;
        chk("distinct_no_conflict", 32'(conflict[0]), 32'h0);
        tick();
        idle();
        #1;
        chk("reg_read_addr7", 32'(rd_data[2][1*WIDTH +: WIDTH]), 32'h33);
        tick();

        // Random traffic, including out-of-range addresses and occasional clears.
        repeat (400) begin
            rand_in(19, 50);
            init = ($urandom_range(63, 0) == 0);
            tick();
        end
        init = 0;
        idle();
        repeat (20) if (ready[0] !== 1'b1) tick();

        // Clear via init_i, then reset when clr_cnt reaches 9.
        init = 1; tick(); init = 0;
        #1;
        chk("init_drops_ready", 32'(ready[0]), 32'h0);
        repeat (9) begin rand_in(19, 80); tick(); end
        reset = 1; tick(); reset = 0;
        count_clear("clear_len_after_midreset");

        // Out-of-range writes/reads at addr 20.
        idle(); we[0] = 1; wa[0] = 20; wd[0] = 8'hFF; we[2] = 1; wa[2] = 20; wd[2] = 8'hEE;
        for (int p = 0; p < NR; p++) ra[p] = 20;
        drive();
        #1;
        chk("oor_read_bypass", 32'(rd_data[0][0 +: WIDTH]), 32'(INIT));
        tick();
        idle(); ra[0] = 20; drive();
        #1;
        chk("oor_no_conflict", 32'(conflict[0]), 32'h0);
        tick();

        // Sweep all entries through every variant.
        for (int b = 0; b < DEPTH; b += NR) begin
            idle();
            for (int p = 0; p < NR; p++) ra[p] = 5'(b + p);
            drive();
            tick(); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_mport_init.md
# ram_mport_init

Parametrised multi-ported register-file RAM with NUM_RD read ports and NUM_WR write ports. It is the generalised successor of the fixed 8-read/4-write RAM used for rename and issue tables. Over that block it adds:
- a selectable combinational or registered read path;
- write-to-read bypass;
- deterministic priority when write ports collide;
- a multi-cycle clear sequencer, replacing the single-cycle bulk reset, with a ready handshake.

It sits under the rename map table, the free list and the active list.

## Interface
Parameters:
- DEPTH, 16, number of entries.
- INDEX, 4, address width; DEPTH <= 2**INDEX.
- WIDTH, 8, data width.
- NUM_RD, 8, read port count (>=1).
- NUM_WR, 4, write port count (>=1).
- RD_LATENCY, 0, read latency: 0 = combinational read, 1 = registered read.
- BYPASS, 1, 1 = the read path forwards the same-cycle write data.
- INIT_VALUE, 0, WIDTH-bit value written into every entry by the clear sequence.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- init_i  in  1  request a clear sequence; honoured only in READY
- ready_o  out  1  1 = array usable; 0 while clearing
- rd_addr_i  in  NUM_RD*INDEX  packed read addresses; port p uses bits [p*INDEX +: INDEX]
- rd_data_o  out  NUM_RD*WIDTH  packed read data
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR*INDEX  packed write addresses
- wr_data_i  in  NUM_WR*WIDTH  packed write data
- wr_conflict_o  out  1  registered; 1 for one cycle after a cycle in which two or more enabled writes targeted the same address

## Operation
- State machine with two states: CLEAR and READY.
- Reset (synchronous, active-high) behaviour:
  - State goes to CLEAR and clr_cnt goes to 0.
  - ready_o = 0 and wr_conflict_o = 0.
  - Every registered rd_data_o lane = INIT_VALUE.
  - Reset asserted mid-clear restarts the sequence at entry 0.
- CLEAR state:
  - Each cycle writes INIT_VALUE to entry clr_cnt, then increments clr_cnt.
  - When clr_cnt = DEPTH-1 is written, the state goes to READY on the next edge.
  - A clear therefore takes exactly DEPTH cycles.
  - wr_en_i is ignored and init_i is ignored.
  - All rd_data_o lanes read INIT_VALUE, regardless of address or latency mode.
- READY state:
  - ready_o = 1.
  - init_i = 1 moves the state to CLEAR with clr_cnt = 0 on the next edge. Writes presented in that same cycle are still performed; the clear then overwrites them.
- Writes (READY only): every enabled port writes its entry at the clock edge.
  - If several enabled ports target the same address, the highest-numbered port wins.
  - wr_conflict_o is set for the next cycle on any such collision.
- Reads, RD_LATENCY=0:
  - rd_data_o[p] = ram[rd_addr_i[p]], combinational.
  - With BYPASS=1, if any enabled write port matches rd_addr_i[p] in the same cycle, the output is that port's data (highest-numbered matching port). Otherwise it is the array value.
- Reads, RD_LATENCY=1:
  - rd_data_o[p] is registered and reflects the address presented in the previous cycle.
  - With BYPASS=1 the registered value includes writes committed at that same edge.
  - With BYPASS=0 the registered value is the pre-write array contents.
- Addresses >= DEPTH: reads return INIT_VALUE and writes are dropped. Neither is a conflict.

## Timing
- Clear: ready_o rises exactly DEPTH cycles after the first cycle with reset=0. The same holds after the cycle in which init_i is sampled in READY.
- Write at edge t is visible to a combinational read from cycle t+1. With BYPASS=1 it is also visible during the write cycle itself.
- Registered read: address at cycle t produces data at cycle t+1.
- wr_conflict_o: one-cycle pulse, lagging the collision by one cycle.
- Back-to-back writes to the same address on consecutive cycles: last write wins, with no stall.

## Test plan
1. Reset for 2 cycles, DEPTH=16, INIT_VALUE=8'hA5:
   - ready_o is 0 for 16 cycles, then 1.
   - All 8 read ports return 8'hA5 throughout.
   - Writes issued during CLEAR are lost.
2. READY, RD_LATENCY=0, BYPASS=1, write port 0 addr 3 data 8'h11; read port 5 addr 3 in the same cycle:
   - rd_data_o lane 5 = 8'h11 in that cycle and in the following cycle.
   - With BYPASS=0, the lane reads 8'hA5 during the write cycle and 8'h11 in the next.
3. Ports 1 and 3 both write addr 7, data 8'h22 and 8'h33:
   - Entry 7 = 8'h33.
   - wr_conflict_o = 1 for exactly the next cycle.
   - Ports writing distinct addresses raise no conflict.
4. RD_LATENCY=1: present addr 7 at cycle t:
   - rd_data_o shows 8'h33 at cycle t+1, not at t.
   - A write to addr 7 at edge t with BYPASS=1 is seen at t+1.
5. Mid-clear reset at clr_cnt=9:
   - The sequence restarts and ready_o is delayed a further 16 cycles.
   - init_i pulse in READY: ready_o drops next cycle and all entries return to 8'hA5 after 16 cycles.
6. Write and read address 20 with DEPTH=16, INDEX=5:
   - The read returns INIT_VALUE.
   - No array entry changes.
   - wr_conflict_o stays 0.
